instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter STARTING_ADDR, default 32'h01000000, meaning the PC loaded at reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entries; legal values are 2 or 4.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_address, output, 32 bits: byte address to main memory, equal to fetch_pc.
REQ-006 The block SHALL have port mem_read_write, output, 1 bit: constant READ (0).
REQ-007 The block SHALL have port mem_data_in, output, 32 bits: constant 0.
REQ-008 The block SHALL have port mem_data_out, input, 32 bits: little-endian word read combinationally from mem_address.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit: a new PC is requested this cycle.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: the target PC.
REQ-011 The block SHALL have port inst_valid, output, 1 bit: the buffer head is valid.
REQ-012 The block SHALL have port inst_ready, input, 1 bit: decode accepts the head.
REQ-013 The block SHALL have port inst, output, 32 bits: the head instruction word.
REQ-014 The block SHALL have port inst_pc, output, 32 bits: the address of the head instruction.
REQ-015 The block SHALL have port fault, output, 1 bit: a misaligned redirect occurred.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and FAULT; it enters IDLE on reset, goes IDLE->FETCH unconditionally on the first clock edge, and goes FETCH->FAULT on a redirect with redirect_pc[1:0]!=0.
REQ-017 In FETCH, with no redirect and the buffer not full (or full with pop=inst_valid&inst_ready this cycle), the block SHALL push {fetch_pc, mem_data_out} and set fetch_pc += 4, with 32-bit wrap and no carry out.
REQ-018 In IDLE or FAULT, and in FETCH when the buffer is full with no pop, the block SHALL neither push nor advance fetch_pc.
REQ-019 A pop SHALL occur when inst_valid&inst_ready; inst and inst_pc SHALL come directly from the head register (no combinational path from mem_data_out).
REQ-020 An aligned redirect in FETCH SHALL flush the whole buffer, load fetch_pc<=redirect_pc and suppress that cycle's push; the next cycle fetches redirect_pc.
REQ-021 A redirect coinciding with a pop SHALL count the popped entry as delivered and flush the rest.
REQ-022 A redirect in IDLE SHALL be ignored.
REQ-023 FAULT SHALL be absorbing until reset: buffer flushed, inst_valid=0, fault=1, fetch_pc frozen.
REQ-024 Latency: after reset_n rises, the first edge enters FETCH and the second edge pushes STARTING_ADDR, so inst_valid=1 after the 2nd edge; after a redirect, the target appears one edge later.
REQ-025 With inst_ready held high, throughput SHALL be one instruction per cycle, in strict PC order without gaps or duplicates.
REQ-026 When the buffer is empty, inst_valid SHALL be 0 and inst/inst_pc SHALL hold their last values.

Reset
REQ-027 On reset_n=0, asynchronously: state=IDLE, fetch_pc=STARTING_ADDR, buffer empty, inst_valid=0, inst=0, inst_pc=0, fault=0, mem_read_write=0, mem_data_in=0.
REQ-028 A reset asserted mid-operation SHALL discard all buffered entries; no pop SHALL complete on the edge during which reset is low.

Structure
REQ-029 Package fetch_pkg SHALL hold STARTING_ADDR, the READ=0/WRITE=1 constants, the FSM state enum and the 64-bit {pc,inst} entry typedef.
REQ-030 The buffer SHALL be a sub-module fetch_buf (push, pop, flush, full, empty, head) parameterised by BUF_DEPTH, with pointers that wrap modulo BUF_DEPTH.

Verification
REQ-031 Scenario: memory holds 0x00000013 at 0x01000000 and 0x00100093 at 0x01000004, inst_ready=1 -> after edge 2, inst=0x00000013 with inst_pc=0x01000000; after edge 3, inst=0x00100093 with inst_pc=0x01000004.
REQ-032 Scenario: inst_ready=0 for 5 cycles -> inst_valid=1, at most BUF_DEPTH entries, mem_address stalls at 0x01000000+4*BUF_DEPTH; on release, PCs stay contiguous with no loss.
REQ-033 Scenario: redirect_pc=0x01000100 with a full buffer and a simultaneous pop -> the popped entry is delivered, the rest are flushed, and the next inst_pc=0x01000100.
REQ-034 Scenario: redirect_pc=0x01000102 -> fault=1 and inst_valid=0 from the next edge onward, holding until reset.
REQ-035 Scenario: reset_n pulsed low mid-stream -> outputs take the REQ-027 values immediately, and fetch restarts at 0x01000000 per REQ-024.
REQ-036 Scenario: fetch_pc=0xFFFFFFFC -> the next fetch address is 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: reset PC,
// memory direction codes, FSM state encoding and the {pc,inst} buffer entry.
package fetch_pkg;

  localparam logic [31:0] STARTING_ADDR = 32'h0100_0000;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit (master) and its memory, redirect
// source and decode consumer (slave).
interface instr_fetch_if;

  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  // inst handshake: an entry transfers on every rising edge where inst_valid
  // and inst_ready are both high; inst_valid never depends on inst_ready, and
  // inst/inst_pc are stable while inst_valid is high and no transfer occurs.
  modport master (
    output mem_address, mem_read_write, mem_data_in,
    output inst_valid, inst, inst_pc, fault,
    input  mem_data_out, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_address, mem_read_write, mem_data_in,
    input  inst_valid, inst, inst_pc, fault,
    output mem_data_out, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Small circular instruction buffer with flush; pointers wrap modulo DEPTH
// and the head is read straight out of the storage registers.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = nxt(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = nxt(rd_ptr_q);
      if (push_ok && !pop_ok) count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the PC through memory, buffers {pc,inst}
// pairs for decode, and honours redirects; a misaligned redirect locks it in FAULT.
module instr_fetch #(
  parameter logic [31:0] STARTING_ADDR = fetch_pkg::STARTING_ADDR,
  parameter int          BUF_DEPTH     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  instr_fetch_if.master          bus,
  output fetch_pkg::fetch_state_e dbg_state_o
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  fetch_entry_t last_q, shown;
  fetch_entry_t head;
  logic         push, pop, flush, full, empty;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .entry_i ('{pc: fetch_pc_q, inst: bus.mem_data_out}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign pop = bus.inst_valid & bus.inst_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          if (|bus.redirect_pc[1:0]) state_d    = FAULT;
          else                       fetch_pc_d = bus.redirect_pc;
        end else if (!full || pop) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      FAULT: flush = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // While empty, the outputs replay the last head that was presented.
  assign shown = empty ? last_q : head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= STARTING_ADDR;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      last_q     <= shown;
    end
  end

  assign bus.mem_address    = fetch_pc_q;
  assign bus.mem_read_write = READ;
  assign bus.mem_data_in    = '0;
  assign bus.inst_valid     = ~empty;
  assign bus.inst           = shown.inst;
  assign bus.inst_pc        = shown.pc;
  assign bus.fault          = (state_q == FAULT);
  assign dbg_state_o        = state_q;

  read_only_chk: assert property (@(posedge clock) disable iff (!reset_n)
    bus.mem_read_write != WRITE);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized ready/redirect
// traffic, all checked each cycle against a queue-based model of the buffer.
module tb_instr_fetch;

  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] START = 32'h0100_0000;

  logic         clock;
  logic         reset_n;
  fetch_state_e dbg_state;

  instr_fetch_if bus ();

  instr_fetch #(.STARTING_ADDR(START), .BUF_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory image ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0100_0000) return 32'h0000_0013;
    if (a == 32'h0100_0004) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.mem_data_out = mem_word(bus.mem_address);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = fetching, 2 = faulted.
  logic [63:0] exp_q[$];
  logic [63:0] m_last  = '0;
  logic [31:0] m_pc    = START;
  int          m_phase = 0;
  logic [63:0] m_shown;
  logic [63:0] cmp_e;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_pc    = START;
      m_last  = '0;
      exp_q.delete();
    end else begin
      m_shown = (exp_q.size() != 0) ? exp_q[0] : m_last;
      m_last  = m_shown;
      if (exp_q.size() != 0 && bus.inst_ready) void'(exp_q.pop_front());
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (bus.redirect_valid) begin
            exp_q.delete();
            if (bus.redirect_pc[1:0] != 2'b00) m_phase = 2;
            else m_pc = bus.redirect_pc;
          end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
          end
        end
        default: exp_q.delete();
      endcase
    end
  end

  always @(negedge clock) begin
    cmp_e = (exp_q.size() != 0) ? exp_q[0] : m_last;
    chk("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
    chk("inst", bus.inst, cmp_e[31:0]);
    chk("inst_pc", bus.inst_pc, cmp_e[63:32]);
    chk("fault", 32'(bus.fault), 32'(m_phase == 2));
    chk("mem_address", bus.mem_address, m_pc);
    chk("mem_read_write", 32'(bus.mem_read_write), 32'(READ));
    chk("mem_data_in", bus.mem_data_in, 32'h0);
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_random();
    bus.inst_ready     = ($urandom_range(0, 9) < 7);
    bus.redirect_valid = ($urandom_range(0, 19) == 0);
    bus.redirect_pc    = START + (32'($urandom_range(0, 255)) << 2);
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick(2);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0100_0000);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Start-up latency and the first two instructions.
    reset_n = 1'b1;
    tick(1);
    chk("edge1_state", 32'(dbg_state), 32'(FETCH));
    chk("edge1_valid", 32'(bus.inst_valid), 32'h0);
    tick(1);
    chk("edge2_valid", 32'(bus.inst_valid), 32'h1);
    chk("edge2_inst", bus.inst, 32'h0000_0013);
    chk("edge2_pc", bus.inst_pc, 32'h0100_0000);
    tick(1);
    chk("edge3_inst", bus.inst, 32'h0010_0093);
    chk("edge3_pc", bus.inst_pc, 32'h0100_0004);

    // Fill the buffer, then redirect while popping the head.
    bus.inst_ready = 1'b0;
    tick(3);
    chk("full_stall_addr", bus.mem_address, 32'h0100_000C);
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0100_0100;
    tick(1);
    bus.redirect_valid = 1'b0;
    chk("redir_flush_valid", 32'(bus.inst_valid), 32'h0);
    chk("redir_hold_pc", bus.inst_pc, 32'h0100_0004);
    tick(1);
    chk("redir_target_pc", bus.inst_pc, 32'h0100_0100);

    // Mid-stream reset, then a stalled restart.
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("async_rst_inst", bus.inst, 32'h0);
    chk("async_rst_pc", bus.inst_pc, 32'h0);
    chk("async_rst_addr", bus.mem_address, 32'h0100_0000);
    tick(1);
    bus.inst_ready = 1'b0;
    reset_n        = 1'b1;
    tick(6);
    chk("stall_valid", 32'(bus.inst_valid), 32'h1);
    chk("stall_head_pc", bus.inst_pc, 32'h0100_0000);
    chk("stall_addr", bus.mem_address, START + 32'(4 * DEPTH));
    bus.inst_ready = 1'b1;
    tick(1);
    chk("release_pc", bus.inst_pc, 32'h0100_0004);

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick(1);
    bus.redirect_valid = 1'b0;
    chk("wrap_addr0", bus.mem_address, 32'hFFFF_FFFC);
    tick(1);
    chk("wrap_addr1", bus.mem_address, 32'h0000_0000);
    chk("wrap_head", bus.inst_pc, 32'hFFFF_FFFC);
    tick(1);
    chk("wrap_next", bus.inst_pc, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick(1);
    end

    // Misaligned redirect: absorbing fault.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0100_0102;
    tick(1);
    bus.redirect_valid = 1'b0;
    chk("fault_set", 32'(bus.fault), 32'h1);
    chk("fault_valid", 32'(bus.inst_valid), 32'h0);
    for (int i = 0; i < 12; i++) begin
      drive_random();
      tick(1);
    end
    chk("fault_hold", 32'(bus.fault), 32'h1);
    chk("fault_state", 32'(dbg_state), 32'(FAULT));

    // Reset clears the fault; a redirect during IDLE is ignored.
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    reset_n            = 1'b0;
    tick(1);
    chk("fault_clear", 32'(bus.fault), 32'h0);
    reset_n            = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0200_0000;
    tick(1);
    bus.redirect_valid = 1'b0;
    tick(1);
    chk("idle_redir_ignored", bus.inst_pc, 32'h0100_0000);
    chk("idle_redir_valid", 32'(bus.inst_valid), 32'h1);

    for (int i = 0; i < 100; i++) begin
      drive_random();
      tick(1);
    end
    bus.redirect_valid = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
